// File: rtl/convertidor_bcd_secuencial_if.sv
// Start/done handshake bundle between the datapath and the BCD converter.
// The master side drives the request and the binary value; the slave side
// (the converter) returns busy, the completion pulse and the result.
interface convertidor_bcd_secuencial_if #(
  parameter int ANCHO   = 16,
  parameter int DIGITOS = 5
);
  logic                   inicio;
  logic [ANCHO-1:0]       dato;
  logic                   ocupado;
  logic                   listo;
  logic [4*DIGITOS-1:0]   decimal;
  logic                   negativo;

  modport master (
    output inicio,
    output dato,
    input  ocupado,
    input  listo,
    input  decimal,
    input  negativo
  );

  modport slave (
    input  inicio,
    input  dato,
    output ocupado,
    output listo,
    output decimal,
    output negativo
  );
endinterface

// File: rtl/convertidor_bcd_secuencial.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// A request accepted in REPOSO runs ANCHO shift/add-3 iterations; the final
// iteration loads the registered result and pulses listo for one cycle.
// Optional feature macro: CONVERTIDOR_BCD_SIGNO_EN -- treats dato as two's
// complement, converts its magnitude and reports the sign on negativo.
module convertidor_bcd_secuencial #(
  parameter int ANCHO   = 16,
  parameter int DIGITOS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  convertidor_bcd_secuencial_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITOS;
  localparam int CNT_W = $clog2(ANCHO + 1);

  function automatic logic [63:0] pot10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMITE_BCD = pot10(DIGITOS);
  localparam logic [63:0] MAX_BIN    = (64'd1 << ANCHO) - 64'd1;

  if (ANCHO < 4 || ANCHO > 32) begin : g_anchoInvalido
    $error("convertidor_bcd_secuencial: ANCHO must lie in 4..32");
  end

  if (LIMITE_BCD <= MAX_BIN) begin : g_digitosInsuficientes
    $error("convertidor_bcd_secuencial: DIGITOS too small for ANCHO");
  end

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVIERTE = 2'd1,
    FIN       = 2'd2
  } estado_t;

  estado_t                r_estado;
  estado_t                w_estadoSig;
  logic [BCD_W-1:0]       r_scratch;
  logic [ANCHO-1:0]       r_desp;
  logic [CNT_W-1:0]       r_cuenta;
  logic [BCD_W-1:0]       r_decimal;
  logic                   r_listo;
  logic [BCD_W-1:0]       w_ajustado;
  logic [BCD_W+ANCHO-1:0] w_conjunto;
  logic [ANCHO-1:0]       w_magnitud;
  logic                   w_ultima;

`ifdef CONVERTIDOR_BCD_SIGNO_EN
  logic r_signoPend;
  logic r_negativo;

  // The most negative value negates to itself, which read unsigned is exactly its magnitude.
  assign w_magnitud   = bus.dato[ANCHO-1] ? (~bus.dato + ANCHO'(1)) : bus.dato;
  assign bus.negativo = r_negativo;
`else
  assign w_magnitud   = bus.dato;
  assign bus.negativo = 1'b0;
`endif

  assign w_ultima    = (r_cuenta == CNT_W'(ANCHO - 1));
  assign w_conjunto  = {w_ajustado, r_desp} << 1;
  assign bus.ocupado = (r_estado != REPOSO);
  assign bus.listo   = r_listo;
  assign bus.decimal = r_decimal;

  // Add 3 to every scratch digit of 5 or more so the following shift carries correctly into the next digit.
  always_comb begin
    w_ajustado = r_scratch;
    for (int d = 0; d < DIGITOS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) w_ajustado[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
    end
  end

  // State register of the request/convert/finish sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= REPOSO;
    else        r_estado <= w_estadoSig;
  end

  // Next-state logic: accept only when idle, leave CONVIERTE on the last iteration.
  always_comb begin
    w_estadoSig = r_estado;
    case (r_estado)
      REPOSO:    if (bus.inicio) w_estadoSig = CONVIERTE;
      CONVIERTE: if (w_ultima)   w_estadoSig = FIN;
      FIN:       w_estadoSig = REPOSO;
      default:   w_estadoSig = REPOSO;
    endcase
  end

  // Datapath: load on acceptance, iterate in CONVIERTE, publish the result on the last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch   <= '0;
      r_desp      <= '0;
      r_cuenta    <= '0;
      r_decimal   <= '0;
      r_listo     <= 1'b0;
`ifdef CONVERTIDOR_BCD_SIGNO_EN
      r_signoPend <= 1'b0;
      r_negativo  <= 1'b0;
`endif
    end else begin
      r_listo <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (bus.inicio) begin
            r_desp      <= w_magnitud;
            r_scratch   <= '0;
            r_cuenta    <= '0;
`ifdef CONVERTIDOR_BCD_SIGNO_EN
            r_signoPend <= bus.dato[ANCHO-1];
`endif
          end
        end
        CONVIERTE: begin
          r_scratch <= w_conjunto[BCD_W+ANCHO-1:ANCHO];
          r_desp    <= w_conjunto[ANCHO-1:0];
          r_cuenta  <= r_cuenta + CNT_W'(1);
          if (w_ultima) begin
            r_decimal  <= w_conjunto[BCD_W+ANCHO-1:ANCHO];
            r_listo    <= 1'b1;
`ifdef CONVERTIDOR_BCD_SIGNO_EN
            r_negativo <= r_signoPend;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convertidor_bcd_secuencial.sv
// Self-checking bench for convertidor_bcd_secuencial. Two instances (8-bit/3
// digits and 16-bit/5 digits) are checked every cycle against a cycle-count
// and arithmetic reference model; directed values pin the expected results.
// Honours CONVERTIDOR_BCD_SIGNO_EN for the signed variant.
module tb_convertidor_bcd_secuencial;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  convertidor_bcd_secuencial_if #(.ANCHO(8),  .DIGITOS(3)) bus8();
  convertidor_bcd_secuencial_if #(.ANCHO(16), .DIGITOS(5)) bus16();

  convertidor_bcd_secuencial #(.ANCHO(8), .DIGITOS(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  convertidor_bcd_secuencial #(.ANCHO(16), .DIGITOS(5)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decimal digits of v, units digit in the low nibble.
  function automatic logic [63:0] bcdRef(input longint v, input int digits);
    logic [63:0] r;
    longint      t;
    r = '0;
    t = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Numeric value of a w-bit input word as the converter is meant to read it.
  function automatic longint valueOf(input logic [31:0] raw, input int w);
    longint r;
    r = 0;
    for (int i = 0; i < w; i++) if (raw[i]) r = r + (longint'(1) << i);
`ifdef CONVERTIDOR_BCD_SIGNO_EN
    if (raw[w-1]) r = r - (longint'(1) << w);
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  int          m8Busy;
  int          m16Busy;
  longint      m8Mag;
  longint      m16Mag;
  bit          m8NegPend;
  bit          m16NegPend;
  logic [63:0] exp8Dec;
  logic [63:0] exp16Dec;
  bit          exp8Neg;
  bit          exp16Neg;

  // Reference model: a request taken while idle keeps the block busy for ANCHO+1 cycles,
  // and the result of the arithmetic conversion appears in the last of them.
  always @(posedge clk or negedge rst_n) begin
    longint v;
    if (!rst_n) begin
      m8Busy = 0;  m16Busy = 0;
      m8Mag = 0;   m16Mag = 0;
      m8NegPend = 1'b0; m16NegPend = 1'b0;
      exp8Dec = '0; exp16Dec = '0;
      exp8Neg = 1'b0; exp16Neg = 1'b0;
    end else begin
      if (m8Busy == 0) begin
        if (bus8.inicio === 1'b1) begin
          v = valueOf(32'(bus8.dato), 8);
          m8NegPend = (v < 0);
          m8Mag = (v < 0) ? -v : v;
          m8Busy = 9;
        end
      end else begin
        m8Busy--;
        if (m8Busy == 1) begin
          exp8Dec = bcdRef(m8Mag, 3);
          exp8Neg = m8NegPend;
        end
      end
      if (m16Busy == 0) begin
        if (bus16.inicio === 1'b1) begin
          v = valueOf(32'(bus16.dato), 16);
          m16NegPend = (v < 0);
          m16Mag = (v < 0) ? -v : v;
          m16Busy = 17;
        end
      end else begin
        m16Busy--;
        if (m16Busy == 1) begin
          exp16Dec = bcdRef(m16Mag, 5);
          exp16Neg = m16NegPend;
        end
      end
    end
  end

  // Compare every output of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("listo8",    64'(bus8.listo),    64'(m8Busy == 1));
    checkOutput("ocupado8",  64'(bus8.ocupado),  64'(m8Busy != 0));
    checkOutput("decimal8",  64'(bus8.decimal),  exp8Dec);
    checkOutput("negativo8", 64'(bus8.negativo), 64'(exp8Neg));
    checkOutput("listo16",    64'(bus16.listo),    64'(m16Busy == 1));
    checkOutput("ocupado16",  64'(bus16.ocupado),  64'(m16Busy != 0));
    checkOutput("decimal16",  64'(bus16.decimal),  exp16Dec);
    checkOutput("negativo16", 64'(bus16.negativo), 64'(exp16Neg));
  end

  task automatic applyStimulus(input bit sel16, input logic [31:0] v,
                               input logic [63:0] expDec, input bit expNeg, input bit doCheck);
    bit seen;
    @(posedge clk); #1;
    if (sel16) begin bus16.inicio = 1'b1; bus16.dato = v[15:0]; end
    else       begin bus8.inicio  = 1'b1; bus8.dato  = v[7:0];  end
    @(posedge clk); #1;
    bus8.inicio  = 1'b0;
    bus16.inicio = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = sel16 ? bus16.listo : bus8.listo;
    end
    if (!seen) checkOutput("listoTimeout", 64'd0, 64'd1);
    if (doCheck && seen) begin
      if (sel16) begin
        checkOutput("litDecimal16",  64'(bus16.decimal),  expDec);
        checkOutput("litNegativo16", 64'(bus16.negativo), 64'(expNeg));
      end else begin
        checkOutput("litDecimal8",  64'(bus8.decimal),  expDec);
        checkOutput("litNegativo8", 64'(bus8.negativo), 64'(expNeg));
      end
    end
  endtask

  int listoCount;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    bus8.inicio  = 1'b0; bus8.dato  = '0;
    bus16.inicio = 1'b0; bus16.dato = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstDecimal8",  64'(bus8.decimal),  64'd0);
    checkOutput("rstOcupado8",  64'(bus8.ocupado),  64'd0);
    checkOutput("rstListo16",   64'(bus16.listo),   64'd0);
    checkOutput("rstDecimal16", 64'(bus16.decimal), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef CONVERTIDOR_BCD_SIGNO_EN
    applyStimulus(1'b0, 32'h0000_00FF, 64'h001, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0000_0080, 64'h128, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0000_007F, 64'h127, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_8000, 64'h32768, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_FFFF, 64'h00001, 1'b1, 1'b1);
`else
    applyStimulus(1'b0, 32'd255, 64'h255, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0,   64'h000, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd9,   64'h009, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd10,  64'h010, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd100, 64'h100, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_FFFF, 64'h65535, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd10000,     64'h10000, 1'b0, 1'b1);
`endif

    for (int v = 0; v < 256; v++) applyStimulus(1'b0, 32'(v), 64'd0, 1'b0, 1'b0);

    // inicio held high with new data every cycle: only every ANCHO+2-th value is taken.
    @(posedge clk); #1;
    bus8.inicio = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus8.dato = 8'($urandom);
      @(posedge clk); #1;
    end
    bus8.inicio = 1'b0;
    repeat (12) @(posedge clk);

    for (int k = 0; k < 200; k++) applyStimulus(1'b1, $urandom, 64'd0, 1'b0, 1'b0);

    // Reset mid-conversion after a known result is on the outputs.
    applyStimulus(1'b0, 32'd137, 64'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd4321, 64'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus8.inicio = 1'b1;  bus8.dato  = 8'd200;
    bus16.inicio = 1'b1; bus16.dato = 16'd54321;
    @(posedge clk); #1;
    bus8.inicio = 1'b0;
    bus16.inicio = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstDecimal8",  64'(bus8.decimal),  64'd0);
    checkOutput("midRstOcupado8",  64'(bus8.ocupado),  64'd0);
    checkOutput("midRstDecimal16", 64'(bus16.decimal), 64'd0);
    checkOutput("midRstOcupado16", 64'(bus16.ocupado), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    listoCount = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus8.listo || bus16.listo) listoCount++;
    end
    checkOutput("noListoAfterRst", 64'(listoCount), 64'd0);
    applyStimulus(1'b0, 32'd99,   64'h099,   1'b0, 1'b1);
    applyStimulus(1'b1, 32'd4096, 64'h04096, 1'b0, 1'b1);

    // Random requests on both instances at once, many of them arriving while busy.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      bus8.inicio  = 1'($urandom_range(0, 1));
      bus8.dato    = 8'($urandom);
      bus16.inicio = 1'($urandom_range(0, 1));
      bus16.dato   = 16'($urandom);
    end
    @(posedge clk); #1;
    bus8.inicio  = 1'b0;
    bus16.inicio = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/convertidor_bcd_secuencial.md
# convertidor_bcd_secuencial

Sequential, parametrised binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per clock. It succeeds the fixed 8-bit combinational converter for wider sensor readings, e.g. 16-bit luminosity counts, where a combinational add-3 array is too large or too slow. It sits between the processor/sensor datapath and the 7-segment display driver, with a start/done handshake.

## Interface
- ANCHO, 16: binary input width; legal range 4..32.
- DIGITOS, 5: BCD output digits. Elaboration must fail (`$error`) if 10^DIGITOS <= 2^ANCHO - 1.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- inicio  input  1  start request; sampled only in REPOSO.
- dato  input  ANCHO  binary value; captured on the accepting edge.
- ocupado  output  1  high whenever state is not REPOSO.
- listo  output  1  one-cycle pulse; decimal valid.
- decimal  output  4*DIGITOS  packed BCD; digit 0 (units) in bits [3:0].
- negativo  output  1  sign of the last result; tied 0 when CONVERTIDOR_BCD_SIGNO_EN is undefined.

## Operation
- States: REPOSO -> CONVIERTE -> FIN -> REPOSO.
- REPOSO with inicio=1 at an edge: latch dato (or its magnitude) into the shift register, clear the BCD scratch register, set the iteration counter to 0, and go to CONVIERTE.
- REPOSO with inicio=0: hold.
- CONVIERTE, one iteration per edge:
  - Add 3 to every scratch digit that is >= 5.
  - Shift {scratch, shift register} left by 1.
  - Increment the counter.
- On the iteration where the counter reaches ANCHO-1, register the final scratch value into decimal, set listo=1, and go to FIN.
- FIN: listo returns to 0 on the next edge; go to REPOSO.
- inicio is ignored in CONVIERTE and FIN. There is no queueing; a request while ocupado=1 is lost.
- decimal and negativo hold the last result until the next completion. They do not change at acceptance or during conversion.
- The scratch register is 4*DIGITOS bits. The counter is $clog2(ANCHO+1) bits and never wraps within a conversion.
- Reset (async, any state): state=REPOSO, decimal=0, negativo=0, listo=0, ocupado=0, scratch and counter cleared. An in-flight conversion is discarded with no listo.

## Timing
- inicio accepted at edge t0: ocupado=1 from t0. The ANCHO iterations occur at edges t0+1 … t0+ANCHO.
- The final iteration's edge (t0+ANCHO) also loads decimal and raises listo, so the result is visible during cycle t0+ANCHO .. t0+ANCHO+1.
- Edge t0+ANCHO+1: listo=0, ocupado=0, state REPOSO.
- The earliest next acceptance is edge t0+ANCHO+2, so throughput is one conversion per ANCHO+2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CONVERTIDOR_BCD_SIGNO_EN defined:
  - dato is two's complement.
  - At acceptance, negativo_pending = dato[ANCHO-1], and the shift register is loaded with |dato|.
  - -2^(ANCHO-1) converts to magnitude 2^(ANCHO-1), which fits unsigned in ANCHO bits.
  - negativo updates together with decimal.
- Undefined:
  - dato is unsigned.
  - negativo is constant 0.
  - No negation logic is synthesised.

## Test plan
- ANCHO=8, DIGITOS=3, unsigned, dato=8'd255 pulsed at t0 -> listo only in cycle t0+8; decimal=12'h255; ocupado low after t0+9.
- ANCHO=8, unsigned, sweep 0..255 -> every decimal matches the reference BCD. Edge values: 0 -> 12'h000, 9 -> 12'h009, 10 -> 12'h010, 100 -> 12'h100.
- ANCHO=16, DIGITOS=5, dato=16'hFFFF -> decimal=20'h65535 after 16 cycles. dato=16'd10000 -> 20'h10000.
- inicio held high continuously, dato changing every cycle -> only the values at t0 and t0+10 are converted; listo pulses at t0+8 and t0+18; intermediate dato values are ignored.
- rst_n asserted at t0+4 mid-conversion -> outputs 0 immediately. No listo appears, and a fresh conversion after release gives the correct value.
- With CONVERTIDOR_BCD_SIGNO_EN, ANCHO=8:
  - 8'hFF -> negativo=1, decimal=12'h001.
  - 8'h80 -> negativo=1, decimal=12'h128.
  - 8'h7F -> negativo=0, decimal=12'h127.
